uart_top: RTL and testbench



---
 rtl/uart_top.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_uart_top.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_top.sv
// uart_top: full-duplex 8N1 UART, one transmitter and one receiver on clk.
// Bit time is CLKS_PER_BIT = CLK_FREQ / BAUD_RATE clock cycles (truncating).
// Optional macro UART_PARITY_EN adds an even parity bit after data bit 7
// (11-bit frame); frames with a parity mismatch are dropped on receive.
//
// TX state | meaning
// INIT     | line high for one bit time after reset, tx_busy held high
// IDLE     | ready, waiting for tx_start
// START    | driving the start bit (0)
// DATA     | driving data bits 0..7, LSB first
// PARITY   | driving the even parity bit (UART_PARITY_EN only)
// STOP     | driving the stop bit (1)
//
// RX state | meaning
// IDLE     | waiting for the synchronized line to go low
// START    | half a bit time in, confirm the start bit or reject a glitch
// DATA     | sampling data bits mid-bit, LSB first
// PARITY   | sampling the parity bit mid-bit (UART_PARITY_EN only)
// STOP     | sampling the stop bit; on a framing error wait for line high
module uart_top #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data_in,
    input  logic       tx_start,
    output logic       uart_tx_out,
    input  logic       uart_rx_in,
    output logic [7:0] rx_data_out,
    output logic       rx_data_valid,
    output logic       tx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        TX_INIT,
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    tx_state_t      r_tx_state;
    logic [CW-1:0]  r_tx_cnt;
    logic [7:0]     r_tx_shift;
    logic [2:0]     r_tx_idx;
    logic           r_tx_out;
    logic           r_tx_busy;
`ifdef UART_PARITY_EN
    logic           r_tx_par;
    logic           r_rx_perr;
`endif

    rx_state_t      r_rx_state;
    logic [CW-1:0]  r_rx_cnt;
    logic [7:0]     r_rx_shift;
    logic [2:0]     r_rx_idx;
    logic           r_rx_ferr;
    logic           r_rx_meta;
    logic           r_rx_sync;
    logic [7:0]     r_rx_data;
    logic           r_rx_valid;
    logic           w_rx_frame_ok;

    assign uart_tx_out   = r_tx_out;
    assign tx_busy       = r_tx_busy;
    assign rx_data_out   = r_rx_data;
    assign rx_data_valid = r_rx_valid;

    // Transmit FSM: one down-counter per bit time, shift register feeds the line LSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_INIT;
            r_tx_cnt   <= BIT_LAST;
            r_tx_shift <= 8'h00;
            r_tx_idx   <= 3'd0;
            r_tx_out   <= 1'b1;
            r_tx_busy  <= 1'b1;
`ifdef UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            case (r_tx_state)
                TX_INIT: begin
                    if (r_tx_cnt == '0) begin
                        r_tx_state <= TX_IDLE;
                        r_tx_busy  <= 1'b0;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - CNT_ONE;
                    end
                end
                TX_IDLE: begin
                    if (tx_start) begin
                        r_tx_shift <= tx_data_in;
`ifdef UART_PARITY_EN
                        r_tx_par   <= ^tx_data_in;
`endif
                        r_tx_busy  <= 1'b1;
                        r_tx_out   <= 1'b0;
                        r_tx_cnt   <= BIT_LAST;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == '0) begin
                        r_tx_out   <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_idx   <= 3'd0;
                        r_tx_cnt   <= BIT_LAST;
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - CNT_ONE;
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == '0) begin
                        r_tx_cnt <= BIT_LAST;
                        if (r_tx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            r_tx_out   <= r_tx_par;
                            r_tx_state <= TX_PARITY;
`else
                            r_tx_out   <= 1'b1;
                            r_tx_state <= TX_STOP;
`endif
                        end else begin
                            r_tx_out   <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_idx   <= r_tx_idx + 3'd1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt - CNT_ONE;
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    if (r_tx_cnt == '0) begin
                        r_tx_out   <= 1'b1;
                        r_tx_cnt   <= BIT_LAST;
                        r_tx_state <= TX_STOP;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - CNT_ONE;
                    end
                end
`endif
                TX_STOP: begin
                    if (r_tx_cnt == '0) begin
                        r_tx_busy  <= 1'b0;
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_tx_out   <= 1'b1;
                    r_tx_busy  <= 1'b1;
                    r_tx_cnt   <= BIT_LAST;
                    r_tx_state <= TX_INIT;
                end
            endcase
        end
    end

    // Two-flop synchronizer on the serial input; the line reads as idle (1) in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx_in;
            r_rx_sync <= r_rx_meta;
        end
    end

`ifdef UART_PARITY_EN
    assign w_rx_frame_ok = !r_rx_ferr && !r_rx_perr;
`else
    assign w_rx_frame_ok = !r_rx_ferr;
`endif

    // Receive FSM: start bit confirmed at half a bit, then every bit sampled mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_shift <= 8'h00;
            r_rx_idx   <= 3'd0;
            r_rx_ferr  <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_perr  <= 1'b0;
`endif
        end else begin
            r_rx_valid <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_ferr <= 1'b0;
                    if (!r_rx_sync) begin
                        r_rx_cnt   <= HALF_LAST;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == '0) begin
                        if (r_rx_sync) begin
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_cnt   <= BIT_LAST;
                            r_rx_idx   <= 3'd0;
                            r_rx_state <= RX_DATA;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == '0) begin
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        r_rx_cnt   <= BIT_LAST;
                        if (r_rx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            r_rx_state <= RX_PARITY;
`else
                            r_rx_state <= RX_STOP;
`endif
                        end else begin
                            r_rx_idx <= r_rx_idx + 3'd1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - CNT_ONE;
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (r_rx_cnt == '0) begin
                        r_rx_perr  <= r_rx_sync ^ (^r_rx_shift);
                        r_rx_cnt   <= BIT_LAST;
                        r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - CNT_ONE;
                    end
                end
`endif
                RX_STOP: begin
                    // A low stop bit marks the frame bad; the counter parks at zero
                    // so the line is polled until it returns high.
                    if (r_rx_cnt != '0) begin
                        r_rx_cnt <= r_rx_cnt - CNT_ONE;
                    end else if (r_rx_sync) begin
                        if (w_rx_frame_ok) begin
                            r_rx_data  <= r_rx_shift;
                            r_rx_valid <= 1'b1;
                        end
                        r_rx_ferr  <= 1'b0;
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_rx_ferr <= 1'b1;
                    end
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: scoreboard bench for uart_top at 50 MHz / 115200 baud.
// Loopback is a mux so the bench can also drive the receive line directly.
module tb_uart_top;

    localparam int CPB = 434;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data_in = 8'h00;
    logic       tx_start = 1'b0;
    logic       uart_tx_out;
    logic       uart_rx_in;
    logic [7:0] rx_data_out;
    logic       rx_data_valid;
    logic       tx_busy;

    logic       loop_en = 1'b1;
    logic       rx_line = 1'b1;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_valid = 0;
    int         n_unexp = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_rx = 8'h00;

    assign uart_rx_in = loop_en ? uart_tx_out : rx_line;

    uart_top #(.CLK_FREQ(50000000), .BAUD_RATE(115200)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_data_in   (tx_data_in),
        .tx_start     (tx_start),
        .uart_tx_out  (uart_tx_out),
        .uart_rx_in   (uart_rx_in),
        .rx_data_out  (rx_data_out),
        .rx_data_valid(rx_data_valid),
        .tx_busy      (tx_busy)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] f;
        f      = 11'h7FF;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_PARITY_EN
        f[9]   = ^d;
`endif
        return f;
    endfunction

    // Scoreboard: every valid pulse pops one expected byte.
    always @(negedge clk) begin : rx_mon
        logic [7:0] e;
        if (rx_data_valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                n_unexp++;
            end else begin
                e = exp_q.pop_front();
                last_rx = e;
                check("rx_data", 32'(rx_data_out), 32'(e));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (tx_busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("tx_idle_timeout", 32'(tx_busy), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit push);
        wait_idle();
        tx_data_in = b;
        tx_start   = 1'b1;
        if (push) exp_q.push_back(b);
        @(negedge clk);
        tx_start   = 1'b0;
    endtask

    task automatic wait_rx();
        int n = 0;
        while (exp_q.size() != 0 && n < NB * CPB + 2000) begin
            @(negedge clk);
            n++;
        end
        check("rx_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop_bit);
        logic [10:0] f;
        f = frame_bits(d);
        f[NB-1] = stop_bit;
        for (int i = 0; i < NB; i++) begin
            rx_line = f[i];
            repeat (CPB) @(negedge clk);
        end
        rx_line = 1'b1;
    endtask

    initial begin : main
        int          n;
        int          v0;
        logic [10:0] f;
        logic [7:0]  seq [3];
        seq[0] = 8'h5A;
        seq[1] = 8'hFF;
        seq[2] = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx_out", 32'(uart_tx_out), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd1);
        check("rst_valid", 32'(rx_data_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data_out), 32'h00);

        // INIT guard length
        rst_n = 1'b1;
        n = 0;
        while (tx_busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("init_len", 32'(n), 32'(CPB));

        // First loopback byte and stop-bit lag between valid and busy fall
        v0 = n_valid;
        send_byte(8'hA5, 1'b1);
        n = 0;
        while (n_valid == v0 && n < NB * CPB + 2000) begin
            @(negedge clk);
            n++;
        end
        check("rx_a5_seen", 32'(n_valid - v0), 32'd1);
        n = 0;
        while (tx_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("busy_lag", 32'(n >= 200 && n <= 240), 32'd1);

        // Back-to-back bytes
        foreach (seq[k]) begin
            send_byte(seq[k], 1'b1);
            wait_rx();
        end

        // Line waveform for 0x01, checked at the first and last cycle of every bit
        wait_idle();
        f = frame_bits(8'h01);
        tx_data_in = 8'h01;
        tx_start   = 1'b1;
        exp_q.push_back(8'h01);
        @(negedge clk);
        tx_start   = 1'b0;
        for (int i = 1; i <= NB * CPB; i++) begin
            if (i > 1) @(negedge clk);
            if ((i % CPB) == 1 || (i % CPB) == 0)
                check("tx_wave", 32'(uart_tx_out), 32'(f[(i - 1) / CPB]));
        end
        wait_rx();

        // Start strobe while busy is dropped; mid-frame data changes ignored
        v0 = n_valid;
        send_byte(8'h11, 1'b1);
        repeat (100) @(negedge clk);
        tx_data_in = 8'h33;
        tx_start   = 1'b1;
        @(negedge clk);
        tx_start   = 1'b0;
        tx_data_in = 8'hEE;
        wait_rx();
        wait_idle();
        repeat (NB * CPB + 500) @(negedge clk);
        check("busy_drop_count", 32'(n_valid - v0), 32'd1);
        check("busy_drop_unexp", 32'(n_unexp), 32'd0);

        // Glitch rejection on the receive line
        loop_en = 1'b0;
        rx_line = 1'b1;
        v0 = n_valid;
        repeat (10) @(negedge clk);
        rx_line = 1'b0;
        repeat (100) @(negedge clk);
        rx_line = 1'b1;
        repeat (NB * CPB) @(negedge clk);
        check("glitch_novalid", 32'(n_valid - v0), 32'd0);

        // Framing error: stop bit low
        drive_frame(8'h3C, 1'b0);
        repeat (CPB) @(negedge clk);
        check("ferr_novalid", 32'(n_valid - v0), 32'd0);
        check("ferr_data_hold", 32'(rx_data_out), 32'(last_rx));

        // Receiver recovers with a clean externally driven frame
        exp_q.push_back(8'h96);
        drive_frame(8'h96, 1'b1);
        wait_rx();

        // Reset mid-frame
        loop_en = 1'b1;
        repeat (CPB) @(negedge clk);
        v0 = n_valid;
        send_byte(8'h77, 1'b0);
        repeat (1000) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_tx_out", 32'(uart_tx_out), 32'd1);
        check("midrst_busy", 32'(tx_busy), 32'd1);
        check("midrst_valid", 32'(rx_data_valid), 32'd0);
        check("midrst_rx_data", 32'(rx_data_out), 32'h00);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'hC3, 1'b1);
        wait_rx();
        check("midrst_count", 32'(n_valid - v0), 32'd1);
        check("final_unexp", 32'(n_unexp), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
